// File: rtl/bypass_adder_pipe.sv
// bypass_adder_pipe
//   Pipelined carry-bypass (carry-skip) adder/subtractor. Operands are cut into
//   BLOCK-bit skip blocks. Each pipeline stage resolves one block. A block's
//   carry-out takes the bypass path when every bit of that block propagates.
//   There is one register per block, and the last one is the output register,
//   so the latency from accept to out_valid is NBLK cycles when nothing stalls.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready drops only while the output stalls
//   A, B, Cin, Sub      operands; Sub=1 computes A-B (Cin is ignored)
//   out_valid/out_ready output handshake
//   S, Cout, Ovf        result, MSB carry-out (no-borrow for Sub), signed overflow
//   Skip                bit k set when block k took the bypass path
module bypass_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic                   Cin,
    input  logic                   Sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       S,
    output logic                   Cout,
    output logic                   Ovf,
    output logic [WIDTH/BLOCK-1:0] Skip
);

    localparam int NBLK = WIDTH / BLOCK;

    typedef struct packed {
        logic [BLOCK-1:0] sum;
        logic             cout;   // ripple carry out of the block
        logic             cmsb;   // carry into the top bit of the block
        logic             p;      // block propagate
    } blk_res_t;

    function automatic blk_res_t blk_add(input logic [BLOCK-1:0] a,
                                         input logic [BLOCK-1:0] b,
                                         input logic             cin);
        blk_res_t r;
        logic     c;
        c      = cin;
        r.sum  = '0;
        r.cmsb = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            if (i == BLOCK - 1) r.cmsb = c;
            r.sum[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
        end
        r.cout = c;
        r.p    = &(a ^ b);
        return r;
    endfunction

    // Register k holds the state after block k has been resolved. Register
    // NBLK-1 is the output register.
    logic             v_q    [NBLK];
    logic [WIDTH-1:0] a_q    [NBLK];
    logic [WIDTH-1:0] b_q    [NBLK];
    logic             c_q    [NBLK];
    logic [WIDTH-1:0] sum_q  [NBLK];
    logic [NBLK-1:0]  skip_q [NBLK];
    logic             ovf_q;

    // Stage inputs: stage 0 sees the prepared operands, stage k sees register k-1.
    logic             in_v    [NBLK];
    logic [WIDTH-1:0] in_a    [NBLK];
    logic [WIDTH-1:0] in_b    [NBLK];
    logic             in_c    [NBLK];
    logic [WIDTH-1:0] in_sum  [NBLK];
    logic [NBLK-1:0]  in_skip [NBLK];

    blk_res_t         res      [NBLK];
    logic [WIDTH-1:0] nxt_sum  [NBLK];
    logic [NBLK-1:0]  nxt_skip [NBLK];
    logic             blk_c    [NBLK];

    logic stall;

    assign stall     = v_q[NBLK-1] & ~out_ready;
    assign in_ready  = ~stall;

    assign out_valid = v_q[NBLK-1];
    assign S         = sum_q[NBLK-1];
    assign Cout      = c_q[NBLK-1];
    assign Skip      = skip_q[NBLK-1];
    assign Ovf       = ovf_q;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtraction is A + ~B + 1; Cin is ignored in that case.
            assign in_v[k]    = in_valid;
            assign in_a[k]    = A;
            assign in_b[k]    = Sub ? ~B : B;
            assign in_c[k]    = Sub ? 1'b1 : Cin;
            assign in_sum[k]  = '0;
            assign in_skip[k] = '0;
        end else begin : g_next
            assign in_v[k]    = v_q[k-1];
            assign in_a[k]    = a_q[k-1];
            assign in_b[k]    = b_q[k-1];
            assign in_c[k]    = c_q[k-1];
            assign in_sum[k]  = sum_q[k-1];
            assign in_skip[k] = skip_q[k-1];
        end

        assign res[k]      = blk_add(in_a[k][k*BLOCK +: BLOCK],
                                     in_b[k][k*BLOCK +: BLOCK], in_c[k]);
        // Bits above the current block are still zero, so OR-ing inserts it.
        assign nxt_sum[k]  = in_sum[k] | (WIDTH'(res[k].sum) << (k * BLOCK));
        assign nxt_skip[k] = in_skip[k] | (NBLK'(res[k].p) << k);
        // When the block propagates, the carry-in goes around the ripple chain.
        assign blk_c[k]    = res[k].p ? in_c[k] : res[k].cout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) begin
                v_q[k]    <= 1'b0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                c_q[k]    <= 1'b0;
                sum_q[k]  <= '0;
                skip_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            // Every stage advances together, bubbles included, so order is kept.
            for (int k = 0; k < NBLK; k++) begin
                v_q[k]    <= in_v[k];
                a_q[k]    <= in_a[k];
                b_q[k]    <= in_b[k];
                c_q[k]    <= blk_c[k];
                sum_q[k]  <= nxt_sum[k];
                skip_q[k] <= nxt_skip[k];
            end
            ovf_q <= res[NBLK-1].cmsb ^ blk_c[NBLK-1];
        end
    end

endmodule

// File: tb/tb_bypass_adder_pipe.sv
`timescale 1ns/1ps
module tb_bypass_adder_pipe;

    localparam int W     = 32;
    localparam int BK    = 8;
    localparam int NB    = W / BK;
    localparam int NRAND = 10000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Cin;
    logic          Sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  S;
    logic          Cout;
    logic          Ovf;
    logic [NB-1:0] Skip;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;

    typedef struct packed {
        logic [W-1:0]  s;
        logic          cout;
        logic          ovf;
        logic [NB-1:0] skip;
    } exp_t;

    exp_t q[$];
    exp_t mon_got;

    bypass_adder_pipe #(.WIDTH(W), .BLOCK(BK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .Ovf(Ovf), .Skip(Skip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: whole-word arithmetic, sign-rule overflow, per-block propagate.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   full;
        logic         c0;
        bx     = sub ? ~b : b;
        c0     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c0};
        e.s    = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bx[W-1]) && (e.s[W-1] != a[W-1]);
        for (int k = 0; k < NB; k++) e.skip[k] = &(a[k*BK +: BK] ^ bx[k*BK +: BK]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Output monitor: every valid output must match the oldest outstanding beat.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            end
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got S=%h with no beat outstanding", S);
                end else begin
                    mon_got = '{s: S, cout: Cout, ovf: Ovf, skip: Skip};
                    if (mon_got !== q[0]) begin
                        errors++;
                        $display("FAIL result: got S=%h Cout=%b Ovf=%b Skip=%b expected S=%h Cout=%b Ovf=%b Skip=%b",
                                 S, Cout, Ovf, Skip, q[0].s, q[0].cout, q[0].ovf, q[0].skip);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        pop_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(A, B, Cin, Sub));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic put(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL put_timeout: beat not accepted after %0d cycles", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            input logic [W-1:0] es, input logic ec, input logic eo,
                            input logic [NB-1:0] ek);
        int n;
        out_ready = 1'b1;
        put(a, b, cin, sub);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({name, "_latency"}, 64'(n), 64'(NB));
        chk({name, "_S"}, 64'(S), 64'(es));
        chk({name, "_Cout"}, 64'(Cout), 64'(ec));
        chk({name, "_Ovf"}, 64'(Ovf), 64'(eo));
        chk({name, "_Skip"}, 64'(Skip), 64'(ek));
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0]  held_s;
    logic [NB-1:0] held_skip;
    exp_t          pin;
    logic          done;

    initial begin
        int got;
        int n;
        int pop0;
        logic [W-1:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        out_ready = 1'b1; done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_S", 64'(S), 64'd0);
        chk("reset_Cout", 64'(Cout), 64'd0);
        chk("reset_Ovf", 64'(Ovf), 64'd0);
        chk("reset_Skip", 64'(Skip), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Hand-computed values pin the reference model.
        pin = model(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        chk("model_sub_S", 64'(pin.s), 64'h7FFF_FFFF);
        chk("model_sub_Ovf", 64'(pin.ovf), 64'd1);
        chk("model_sub_Skip", 64'(pin.skip), 64'b0110);
        pin = model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        chk("model_allp_Cout", 64'(pin.cout), 64'd1);
        chk("model_allp_Skip", 64'(pin.skip), 64'b1111);

        directed("add_ff", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 4'b0000);
        directed("add_allp", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'b1111);
        directed("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4'b1110);
        directed("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 4'b0110);

        // Backpressure: 8 back-to-back beats, stall after two results for 5 cycles.
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) put(W'(i), W'(i) * 32'h0101_0101, 1'b0, 1'b0);
            end
            begin
                got = 0;
                n   = 0;
                while (got < 2 && n < 100) begin
                    @(negedge clk);
                    n++;
                    if (out_valid && out_ready) got++;
                end
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held_s    = S;
                held_skip = Skip;
                chk("bp_third_S", 64'(held_s), 64'h0202_0204);
                chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
                for (int c = 1; c < 5; c++) begin
                    @(negedge clk);
                    chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
                    chk("bp_stall_out_valid", 64'(out_valid), 64'd1);
                    chk("bp_hold_S", 64'(S), 64'(held_s));
                    chk("bp_hold_Skip", 64'(Skip), 64'(held_skip));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                n = 0;
                while (got < 8 && n < 200) begin
                    @(negedge clk);
                    n++;
                    if (out_valid && out_ready) got++;
                end
                chk("bp_result_count", 64'(got), 64'd8);
            end
        join
        @(posedge clk);
        #1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Reset with three beats in flight.
        out_ready = 1'b1;
        put(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        put(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
        put(32'h5555_5555, 32'h0000_0001, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_S", 64'(S), 64'd0);
        chk("midrst_Skip", 64'(Skip), 64'd0);
        @(posedge clk);
        #1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        directed("post_rst", 32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'b1111);

        // Random regression with random gaps and backpressure.
        pop0 = pop_cnt;
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = $urandom;
                    case ($urandom_range(0, 3))
                        0: rb = $urandom;
                        1: rb = ~ra;
                        2: rb = ra;
                        default: rb = ~ra ^ (32'h1 << $urandom_range(0, W - 1));
                    endcase
                    put(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                int cyc;
                cyc = 0;
                while (!(done && q.size() == 0) && cyc < 60000) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk("rand_result_count", 64'(pop_cnt - pop0), 64'(NRAND));
        chk("rand_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
